buzzer_arbiter: RTL and testbench

Shares the single piezo buzzer between three sound requesters: win melody, countdown warning and key click. It latches one-shot requests and grants by fixed priority, with higher priority preempting lower. It sequences each granted channel's beep pattern (beep count, on/off durations, tone pitch) and drives the square-wave buzzer pin. It sits between the game controller's event pulses and the top-level buzzer output, replacing ad-hoc buzzer muxing.

---
 rtl/buzzer_pkg.sv | 28 ++
 rtl/buzzer_if.sv | 22 ++
 rtl/buzzer_tone_gen.sv | 49 ++++
 rtl/buzzer_arbiter.sv | 163 ++++++++++++++++
 tb/tb_buzzer_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and per-channel beep patterns for the buzzer arbiter.
// Channel 0 has the highest priority.
package buzzer_pkg;

    localparam int NUM_CH = 3;

    typedef logic [1:0] ch_t;

    localparam ch_t CH_WIN   = 2'd0;
    localparam ch_t CH_WARN  = 2'd1;
    localparam ch_t CH_CLICK = 2'd2;

    localparam logic [1:0] BEEPS     [NUM_CH] = '{2'd3, 2'd1, 2'd1};
    localparam logic [5:0] ON_TICKS  [NUM_CH] = '{6'd40, 6'd20, 6'd4};
    localparam logic [5:0] OFF_TICKS [NUM_CH] = '{6'd20, 6'd0, 6'd0};

    typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_e;

    function automatic ch_t lowest_set(input logic [NUM_CH-1:0] v);
        ch_t r;
        r = CH_WIN;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) r = ch_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/buzzer_if.sv
// Request/status bundle between the game controller and the buzzer arbiter.
interface buzzer_if;
    import buzzer_pkg::*;

    logic              en;
    logic [NUM_CH-1:0] req;
    logic              busy;
    ch_t               active_ch;
    logic [NUM_CH-1:0] done;
    logic              buzzer_out;

    modport master (
        output en, req,
        input  busy, active_ch, done, buzzer_out
    );

    modport slave (
        input  en, req,
        output busy, active_ch, done, buzzer_out
    );

endinterface

// File: rtl/buzzer_tone_gen.sv
// Loadable half-period square-wave toggler; restart begins a fresh high phase.
module buzzer_tone_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         restart_i,
    input  logic [W-1:0] reload_i,
    output logic         tone_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] reload_q, reload_d;
    logic         out_q, out_d;

    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        out_d    = out_q;
        if (restart_i) begin
            out_d    = 1'b1;
            cnt_d    = reload_i;
            reload_d = reload_i;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                out_d = ~out_q;
                cnt_d = reload_q;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            reload_q <= '0;
            out_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            out_q    <= out_d;
        end
    end

    assign tone_o = en_i & out_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority, preemptive sharing of one piezo buzzer between three
// one-shot sound requesters, each with its own beep pattern and pitch.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int TICK_CYCLES   = 5000,
    parameter int HALF_PERIOD_0 = 250,
    parameter int HALF_PERIOD_1 = 500,
    parameter int HALF_PERIOD_2 = 333
) (
    input  logic     clk,
    input  logic     rst,
    buzzer_if.slave  bus
);

    localparam int TW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HM01  = (HALF_PERIOD_0 > HALF_PERIOD_1) ? HALF_PERIOD_0 : HALF_PERIOD_1;
    localparam int HMAX  = (HM01 > HALF_PERIOD_2) ? HM01 : HALF_PERIOD_2;
    localparam int HW    = (HMAX > 1) ? $clog2(HMAX) : 1;

    state_e            state_q, state_d;
    ch_t               ch_q, ch_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [TW-1:0]     cyc_q, cyc_d;
    logic [5:0]        ticks_q, ticks_d;
    logic [1:0]        beeps_q, beeps_d;

    logic [NUM_CH-1:0] eff;
    ch_t               g;
    logic              preempt;
    logic              expire;
    logic              grant;
    logic              restart;
    logic [HW-1:0]     reload;
    logic              tone;

    function automatic logic [HW-1:0] reload_of(input ch_t c);
        logic [HW-1:0] r;
        unique case (c)
            CH_WIN:  r = HW'(HALF_PERIOD_0 - 1);
            CH_WARN: r = HW'(HALF_PERIOD_1 - 1);
            default: r = HW'(HALF_PERIOD_2 - 1);
        endcase
        return r;
    endfunction

    assign eff     = pend_q | bus.req;
    assign g       = lowest_set(eff);
    assign preempt = (eff != '0) && (g < ch_q);
    assign expire  = (cyc_q == '0) && (ticks_q == '0);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pend_d  = pend_q;
        cyc_d   = cyc_q;
        ticks_d = ticks_q;
        beeps_d = beeps_q;
        grant   = 1'b0;
        restart = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            ch_d    = CH_WIN;
            pend_d  = '0;
            cyc_d   = '0;
            ticks_d = '0;
            beeps_d = '0;
        end else begin
            pend_d = eff;
            unique case (state_q)
                IDLE, DONE: begin
                    grant = (eff != '0);
                    if (!grant) begin
                        state_d = IDLE;
                        ch_d    = CH_WIN;
                    end
                end
                ON, OFF: begin
                    if (preempt) begin
                        grant = 1'b1;
                    end else if (!expire) begin
                        if (cyc_q == '0) begin
                            cyc_d   = TW'(TICK_CYCLES - 1);
                            ticks_d = ticks_q - 6'd1;
                        end else begin
                            cyc_d = cyc_q - TW'(1);
                        end
                    end else if (state_q == OFF) begin
                        state_d = ON;
                        restart = 1'b1;
                        cyc_d   = TW'(TICK_CYCLES - 1);
                        ticks_d = ON_TICKS[ch_q] - 6'd1;
                    end else if (beeps_q != '0) begin
                        beeps_d = beeps_q - 2'd1;
                        cyc_d   = TW'(TICK_CYCLES - 1);
                        // Zero-length gaps chain straight into the next beep.
                        if (OFF_TICKS[ch_q] != '0) begin
                            state_d = OFF;
                            ticks_d = OFF_TICKS[ch_q] - 6'd1;
                        end else begin
                            restart = 1'b1;
                            ticks_d = ON_TICKS[ch_q] - 6'd1;
                        end
                    end else begin
                        state_d = DONE;
                        cyc_d   = '0;
                        ticks_d = '0;
                    end
                end
            endcase
            if (grant) begin
                state_d   = ON;
                ch_d      = g;
                pend_d[g] = 1'b0;
                beeps_d   = BEEPS[g] - 2'd1;
                cyc_d     = TW'(TICK_CYCLES - 1);
                ticks_d   = ON_TICKS[g] - 6'd1;
                restart   = 1'b1;
            end
        end
    end

    assign reload = reload_of(grant ? g : ch_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= CH_WIN;
            pend_q  <= '0;
            cyc_q   <= '0;
            ticks_q <= '0;
            beeps_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            cyc_q   <= cyc_d;
            ticks_q <= ticks_d;
            beeps_q <= beeps_d;
        end
    end

    buzzer_tone_gen #(
        .W (HW)
    ) u_tone (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == ON),
        .restart_i (restart),
        .reload_i  (reload),
        .tone_o    (tone)
    );

    always_comb begin
        bus.done = '0;
        if (state_q == DONE) bus.done[ch_q] = 1'b1;
    end

    assign bus.busy       = (state_q == ON) || (state_q == OFF);
    assign bus.active_ch  = ch_q;
    assign bus.buzzer_out = tone;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with short ticks and tone periods.
// Expected waveforms come from hand-derived pattern formulas.
module tb_buzzer_arbiter;
    import buzzer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    buzzer_if bus();

    buzzer_arbiter #(
        .TICK_CYCLES   (10),
        .HALF_PERIOD_0 (2),
        .HALF_PERIOD_1 (3),
        .HALF_PERIOD_2 (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // t = cycles since the grant edge
    function automatic logic exp_buz(input int ch, input int t);
        int ph;
        case (ch)
            0: begin
                ph = t % 600;
                return (ph < 400) && (((ph / 2) % 2) == 0);
            end
            1: return ((t / 3) % 2) == 0;
            default: return ((t / 4) % 2) == 0;
        endcase
    endfunction

    // Walks one pattern from the grant edge; inj adds extra requests mid-play.
    task automatic play(input int ch, input int len, input int inj,
                        output int bad, output int first);
        bad   = 0;
        first = -1;
        for (int t = 0; t < len; t++) begin
            if (bus.buzzer_out !== exp_buz(ch, t) || bus.busy !== 1'b1 ||
                bus.active_ch !== ch_t'(ch) || bus.done !== 3'b000) begin
                bad++;
                if (first < 0) first = t;
            end
            bus.req = 3'b000;
            if (inj == 1 && (t == 50 || t == 100 || t == 150)) bus.req = 3'b010;
            if (inj == 1 && t == 200) bus.req = 3'b100;
            if (inj == 2 && t == 10) bus.req = 3'b100;
            step(1);
        end
        bus.req = 3'b000;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.req = 3'b001;
        step(3);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.buzzer_out !== 1'b0) begin fails++; $display("FAIL reset_buz got %b want 0", bus.buzzer_out); end
        tests++; if (bus.done !== 3'b000) begin fails++; $display("FAIL reset_done got %b want 000", bus.done); end
        tests++; if (bus.active_ch !== 2'd0) begin fails++; $display("FAIL reset_ch got %0d want 0", bus.active_ch); end
        bus.req = 3'b000;
        rst = 1'b0;
        step(5);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_req_ignored busy got %b want 0", bus.busy); end
    endtask

    task automatic test_click;
        int bad, first;
        bus.req = 3'b100;
        step(1);
        play(2, 40, 0, bad, first);
        tests++; if (bad !== 0) begin fails++; $display("FAIL click_pattern bad=%0d first=%0d want 0", bad, first); end
        tests++; if (bus.done !== 3'b100) begin fails++; $display("FAIL click_done got %b want 100", bus.done); end
        tests++; if (bus.busy !== 1'b0 || bus.buzzer_out !== 1'b0) begin fails++; $display("FAIL click_done_quiet busy=%b buz=%b want 0 0", bus.busy, bus.buzzer_out); end
        step(1);
        tests++; if (bus.done !== 3'b000 || bus.busy !== 1'b0) begin fails++; $display("FAIL click_idle done=%b busy=%b want 000 0", bus.done, bus.busy); end
    endtask

    task automatic test_win;
        int bad, first;
        bus.req = 3'b001;
        step(1);
        play(0, 1600, 0, bad, first);
        tests++; if (bad !== 0) begin fails++; $display("FAIL win_pattern bad=%0d first=%0d want 0", bad, first); end
        tests++; if (bus.done !== 3'b001) begin fails++; $display("FAIL win_done got %b want 001", bus.done); end
        step(1);
        tests++; if (bus.done !== 3'b000 || bus.busy !== 1'b0) begin fails++; $display("FAIL win_idle done=%b busy=%b want 000 0", bus.done, bus.busy); end
    endtask

    task automatic test_preempt;
        int bad, first;
        bus.req = 3'b100;
        step(1);
        play(2, 6, 0, bad, first);
        tests++; if (bad !== 0) begin fails++; $display("FAIL pre_click bad=%0d first=%0d want 0", bad, first); end
        bus.req = 3'b001;
        step(1);
        tests++; if (bus.active_ch !== 2'd0 || bus.buzzer_out !== 1'b1) begin fails++; $display("FAIL pre_grant ch=%0d buz=%b want 0 1", bus.active_ch, bus.buzzer_out); end
        play(0, 1600, 0, bad, first);
        tests++; if (bad !== 0) begin fails++; $display("FAIL pre_win bad=%0d first=%0d want 0", bad, first); end
        tests++; if (bus.done !== 3'b001) begin fails++; $display("FAIL pre_done got %b want 001", bus.done); end
        step(1);
        tests++; if (bus.busy !== 1'b0 || bus.done !== 3'b000) begin fails++; $display("FAIL pre_idle busy=%b done=%b want 0 000", bus.busy, bus.done); end
    endtask

    task automatic test_queue;
        int bad, first;
        bus.req = 3'b001;
        step(1);
        play(0, 1600, 1, bad, first);
        tests++; if (bad !== 0) begin fails++; $display("FAIL q_win bad=%0d first=%0d want 0", bad, first); end
        tests++; if (bus.done !== 3'b001) begin fails++; $display("FAIL q_win_done got %b want 001", bus.done); end
        step(1);
        tests++; if (bus.active_ch !== 2'd1 || bus.busy !== 1'b1) begin fails++; $display("FAIL q_warn_grant ch=%0d busy=%b want 1 1", bus.active_ch, bus.busy); end
        play(1, 200, 0, bad, first);
        tests++; if (bad !== 0) begin fails++; $display("FAIL q_warn bad=%0d first=%0d want 0", bad, first); end
        tests++; if (bus.done !== 3'b010) begin fails++; $display("FAIL q_warn_done got %b want 010", bus.done); end
        step(1);
        tests++; if (bus.active_ch !== 2'd2) begin fails++; $display("FAIL q_click_grant ch=%0d want 2", bus.active_ch); end
        play(2, 40, 0, bad, first);
        tests++; if (bad !== 0) begin fails++; $display("FAIL q_click bad=%0d first=%0d want 0", bad, first); end
        tests++; if (bus.done !== 3'b100) begin fails++; $display("FAIL q_click_done got %b want 100", bus.done); end
        step(1);
        tests++; if (bus.busy !== 1'b0 || bus.active_ch !== 2'd0) begin fails++; $display("FAIL q_idle busy=%b ch=%0d want 0 0", bus.busy, bus.active_ch); end
        step(20);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL q_no_regrant busy=%b want 0", bus.busy); end
    endtask

    task automatic test_replay;
        int bad, first;
        bus.req = 3'b100;
        step(1);
        play(2, 40, 2, bad, first);
        tests++; if (bad !== 0) begin fails++; $display("FAIL rp_first bad=%0d first=%0d want 0", bad, first); end
        tests++; if (bus.done !== 3'b100) begin fails++; $display("FAIL rp_done1 got %b want 100", bus.done); end
        step(1);
        tests++; if (bus.active_ch !== 2'd2 || bus.buzzer_out !== 1'b1) begin fails++; $display("FAIL rp_regrant ch=%0d buz=%b want 2 1", bus.active_ch, bus.buzzer_out); end
        play(2, 40, 0, bad, first);
        tests++; if (bad !== 0) begin fails++; $display("FAIL rp_second bad=%0d first=%0d want 0", bad, first); end
        tests++; if (bus.done !== 3'b100) begin fails++; $display("FAIL rp_done2 got %b want 100", bus.done); end
        bus.req = 3'b010;
        step(1);
        bus.req = 3'b000;
        tests++; if (bus.active_ch !== 2'd1 || bus.busy !== 1'b1) begin fails++; $display("FAIL rp_done_req ch=%0d busy=%b want 1 1", bus.active_ch, bus.busy); end
        play(1, 200, 0, bad, first);
        tests++; if (bus.done !== 3'b010) begin fails++; $display("FAIL rp_warn_done got %b want 010", bus.done); end
        step(1);
    endtask

    task automatic test_en_drop;
        int bad, first;
        int idle_bad;
        bus.req = 3'b001;
        step(1);
        bus.req = 3'b000;
        step(99);
        bus.req = 3'b010;
        step(1);
        bus.req = 3'b000;
        bus.en = 1'b0;
        step(1);
        tests++; if (bus.buzzer_out !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL en_off buz=%b busy=%b want 0 0", bus.buzzer_out, bus.busy); end
        tests++; if (bus.done !== 3'b000) begin fails++; $display("FAIL en_off_done got %b want 000", bus.done); end
        bus.req = 3'b100;
        step(3);
        bus.req = 3'b000;
        bus.en = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.busy !== 1'b0 || bus.buzzer_out !== 1'b0 || bus.done !== 3'b000) idle_bad++;
        end
        tests++; if (idle_bad !== 0) begin fails++; $display("FAIL en_back_idle bad=%0d want 0", idle_bad); end
        bus.req = 3'b010;
        step(1);
        play(1, 200, 0, bad, first);
        tests++; if (bad !== 0) begin fails++; $display("FAIL en_new_req bad=%0d first=%0d want 0", bad, first); end
        tests++; if (bus.done !== 3'b010) begin fails++; $display("FAIL en_new_done got %b want 010", bus.done); end
        step(1);
    endtask

    task automatic test_rst_off;
        bus.req = 3'b001;
        step(1);
        bus.req = 3'b000;
        step(439);
        bus.req = 3'b100;
        step(1);
        bus.req = 3'b000;
        step(9);
        tests++; if (bus.busy !== 1'b1 || bus.buzzer_out !== 1'b0) begin fails++; $display("FAIL rst_in_off busy=%b buz=%b want 1 0", bus.busy, bus.buzzer_out); end
        rst = 1'b1;
        step(1);
        tests++; if (bus.busy !== 1'b0 || bus.buzzer_out !== 1'b0 || bus.done !== 3'b000 || bus.active_ch !== 2'd0) begin fails++; $display("FAIL rst_mid busy=%b buz=%b done=%b ch=%0d want 0 0 000 0", bus.busy, bus.buzzer_out, bus.done, bus.active_ch); end
        rst = 1'b0;
        step(30);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_pend_clear busy=%b want 0", bus.busy); end
    endtask

    initial begin
        bus.en  = 1'b1;
        bus.req = 3'b000;
        test_reset;
        test_click;
        test_win;
        test_preempt;
        test_queue;
        test_replay;
        test_en_drop;
        test_rst_off;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
